// File: rtl/sum_acc_pkg.sv
// Purpose: shared state encoding and default widths for sum_accumulator.
package sum_acc_pkg;

  localparam int unsigned SUM_WIDTH_DEF   = 15;
  localparam int unsigned ACC_WIDTH_DEF   = 24;
  localparam int unsigned COUNT_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accumulator.sv
// Purpose: accumulates a programmed number of adder sums arriving over a
// valid/ready handshake and presents total + sample count over a second
// valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, len            job start pulse (IDLE only) and number of sums
//   in_sum/in_valid/in_ready      input sum stream
//   out_acc/out_count/out_valid/out_ready  result handshake
//   busy                  high while a job is in ACCUM or DONE
//   overflow              sticky carry-out of the accumulator for this job
//
// Build option: define SUM_ACCUMULATOR_SATURATE_EN to clamp the accumulator
// at all-ones on overflow; otherwise it wraps modulo 2^ACC_WIDTH.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic [SUM_WIDTH-1:0]   in_sum,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overflow
);

  localparam int unsigned ADD_WIDTH = ACC_WIDTH + 1;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic                   ovf_q, ovf_d;
  logic [ADD_WIDTH-1:0]   sum_ext;
  logic                   carry;

  // One extra bit on the add exposes the carry that drives overflow.
  assign sum_ext = {1'b0, acc_q} + ADD_WIDTH'(in_sum);
  assign carry   = sum_ext[ACC_WIDTH];

  // State, accumulator, counter and length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone is a transfer.
        if (in_valid) begin
          count_d = count_q + COUNT_WIDTH'(1);
          ovf_d   = ovf_q | carry;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
          // Once clamped, stay clamped until the next job clears overflow.
          acc_d   = (ovf_q | carry) ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
          acc_d   = sum_ext[ACC_WIDTH-1:0];
`endif
          // len_q is non-zero in ACCUM, so len_q-1 cannot underflow.
          if (count_q == len_q - COUNT_WIDTH'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are direct decodes of registered state.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: one default-width instance (a) and one
// 16-bit accumulator instance (b) share all inputs.
module tb_sum_accumulator;
  import sum_acc_pkg::*;

  localparam int unsigned SW = SUM_WIDTH_DEF;
  localparam int unsigned AW = ACC_WIDTH_DEF;
  localparam int unsigned CW = COUNT_WIDTH_DEF;
  localparam int unsigned BW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic [SW-1:0] in_sum = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready_a, out_valid_a, busy_a, ovf_a;
  logic [AW-1:0] out_acc_a;
  logic [CW-1:0] out_count_a;
  logic          in_ready_b, out_valid_b, busy_b, ovf_b;
  logic [BW-1:0] out_acc_b;
  logic [CW-1:0] out_count_b;

  sum_accumulator u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_acc(out_acc_a), .out_count(out_count_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .busy(busy_a), .overflow(ovf_a)
  );

  sum_accumulator #(.ACC_WIDTH(BW)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_sum(in_sum), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_acc(out_acc_b), .out_count(out_count_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .busy(busy_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] sums[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected accumulator for a job total at a given width.
  function automatic logic [63:0] model_acc(input logic [63:0] total, input int w);
    logic [63:0] max;
    max = (64'd1 << w) - 64'd1;
    if (total <= max) return total;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    return max;
`else
    return total & max;
`endif
  endfunction

  function automatic logic [63:0] model_ovf(input logic [63:0] total, input int w);
    return (total > ((64'd1 << w) - 64'd1)) ? 64'd1 : 64'd0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".in_ready"},  {63'd0, in_ready_a | in_ready_b}, 64'd0);
    check({tag, ".out_valid"}, {63'd0, out_valid_a | out_valid_b}, 64'd0);
    check({tag, ".busy"},      {63'd0, busy_a | busy_b}, 64'd0);
    check({tag, ".overflow"},  {63'd0, ovf_a | ovf_b}, 64'd0);
    check({tag, ".acc_a"},     64'(out_acc_a), 64'd0);
    check({tag, ".acc_b"},     64'(out_acc_b), 64'd0);
    check({tag, ".count_a"},   64'(out_count_a), 64'd0);
    check({tag, ".count_b"},   64'(out_count_b), 64'd0);
  endtask

  task automatic check_result(input string tag, input int n, input logic [63:0] total);
    check({tag, ".valid_a"}, 64'(out_valid_a), 64'd1);
    check({tag, ".valid_b"}, 64'(out_valid_b), 64'd1);
    check({tag, ".in_ready"}, 64'(in_ready_a), 64'd0);
    check({tag, ".busy"}, 64'(busy_a), 64'd1);
    check({tag, ".acc_a"}, 64'(out_acc_a), model_acc(total, AW));
    check({tag, ".acc_b"}, 64'(out_acc_b), model_acc(total, BW));
    check({tag, ".count_a"}, 64'(out_count_a), 64'(n));
    check({tag, ".count_b"}, 64'(out_count_b), 64'(n));
    check({tag, ".ovf_a"}, 64'(ovf_a), model_ovf(total, AW));
    check({tag, ".ovf_b"}, 64'(ovf_b), model_ovf(total, BW));
  endtask

  // Runs one job over sums[0..n-1]; poke drives spurious start/len activity.
  task automatic run_job(input string tag, input int n, input bit rand_valid,
                         input int hold, input bit poke);
    logic [63:0] total;
    int idx;
    int guard;
    bit xfer;
    total = 64'd0;
    for (int i = 0; i < n; i++) total += sums[i];
    start = 1'b1;
    len = CW'(n);
    tick();
    start = 1'b0;
    if (poke) len = CW'(n + 3);
    if (n > 0) check({tag, ".accum_ready"}, 64'(in_ready_a), 64'd1);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 20 * n + 100) begin
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_sum = SW'(sums[idx]);
      if (poke) start = ($urandom_range(0, 2) == 0);
      if (idx == n - 1 && in_valid) begin
        if (poke) start = 1'b1;
        check({tag, ".pre_final_valid"}, 64'(out_valid_a), 64'd0);
      end
      xfer = in_valid && in_ready_a;
      tick();
      if (xfer) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (idx < n) check({tag, ".timeout"}, 64'(idx), 64'(n));
    check_result(tag, n, total);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_result({tag, ".hold"}, n, total);
    end
    out_ready = 1'b1;
    start = poke;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, ".post_valid"}, 64'(out_valid_a), 64'd0);
    check({tag, ".post_busy"}, 64'(busy_a | busy_b), 64'd0);
  endtask

  initial begin
    logic [13:0] a, b;
    int n;

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Basic: a/b = 1/1, 0/1, 10/10 -> 2, 1, 20
    sums.delete();
    sums.push_back(64'd2); sums.push_back(64'd1); sums.push_back(64'd20);
    run_job("basic", 3, 1'b0, 0, 1'b0);
    check("basic.acc_hand", 64'(out_acc_a), 64'd23);

    // Zero length
    sums.delete();
    run_job("zero", 0, 1'b0, 2, 1'b0);

    // Handshake stress with spurious start and len changes
    sums.delete();
    sums.push_back(64'd100); sums.push_back(64'd200);
    sums.push_back(64'd300); sums.push_back(64'd400);
    run_job("stress", 4, 1'b1, 5, 1'b1);
    check("stress.acc_hand", 64'(out_acc_a), 64'd1000);

    // Overflow of the 16-bit instance
    sums.delete();
    repeat (3) sums.push_back(64'd32767);
    start = 1'b1; len = CW'(3); tick(); start = 1'b0;
    in_sum = SW'(32767); in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    check("ovf.acc_b_hand", 64'(out_acc_b), 64'd65535);
`else
    check("ovf.acc_b_hand", 64'(out_acc_b), 64'd32765);
`endif
    check("ovf.flag_b", 64'(ovf_b), 64'd1);
    check("ovf.acc_a_hand", 64'(out_acc_a), 64'd98301);
    check("ovf.flag_a", 64'(ovf_a), 64'd0);
    check_result("ovf", 3, 64'd98301);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Next job clears overflow
    sums.delete();
    sums.push_back(64'd5);
    run_job("clear", 1, 1'b0, 0, 1'b0);
    check("clear.ovf_b", 64'(ovf_b), 64'd0);

    // Reset mid-job aborts to idle
    start = 1'b1; len = CW'(10); tick(); start = 1'b0;
    in_sum = SW'(7); in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("midrst.count_pre", 64'(out_count_a), 64'd3);
    rst_n = 1'b0;
    #1;
    check_idle("midrst.async");
    repeat (3) tick();
    check_idle("midrst");
    rst_n = 1'b1;
    tick();

    // Random jobs
    for (int j = 0; j < 30; j++) begin
      n = (j % 5 == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(1, 1023));
      sums.delete();
      for (int i = 0; i < n; i++) begin
        a = 14'($urandom);
        b = 14'($urandom);
        sums.push_back(64'(a) + 64'(b));
      end
      run_job($sformatf("rand%0d", j), n, 1'(j % 2), j % 3, 1'(j % 4 == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
